// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-master memory arbiter.
// Master ids, bus widths and the grant-lock state encoding.
package xw_mem_pkg;

  localparam int XW_ADDR_W = 32;
  localparam int XW_DATA_W = 32;
  localparam int XW_BE_W   = 4;

  typedef logic master_id_t;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_st_t;

  function automatic master_id_t rr_pick(
    input master_id_t last
  );
    return ~last;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle used for both master ports and the bus port.
// The requester drives master; the responder drives slave.
interface mem_arbiter_if;
  import xw_mem_pkg::*;

  logic                 ready;
  logic [XW_ADDR_W-1:0] addr;
  logic [XW_DATA_W-1:0] write_data;
  logic [XW_BE_W-1:0]   byte_enable;
  logic                 write_req;
  logic                 read_req;
  logic [XW_DATA_W-1:0] read_data;
  logic                 read_data_valid;

  modport master (
    input  ready,
    input  read_data,
    input  read_data_valid,
    output addr,
    output write_data,
    output byte_enable,
    output write_req,
    output read_req
  );

  modport slave (
    output ready,
    output read_data,
    output read_data_valid,
    input  addr,
    input  write_data,
    input  byte_enable,
    input  write_req,
    input  read_req
  );

endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// In-order record of which master issued each outstanding read.
// Pop on empty is ignored; push on full is ignored.
module mem_arbiter_id_fifo
  import xw_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  master_id_t             i_id,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output master_id_t             o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  master_id_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd];
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the memory mapper request port.
// Round-robin or fixed priority, with in-order read return steering.
module mem_arbiter
  import xw_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FIXED_PRIORITY  = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  i_m0,
  mem_arbiter_if.slave  i_m1,
  mem_arbiter_if.master o_bus,
  output logic          o_err_unexpected_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic          w_req0;
  logic          w_req1;
  logic          w_rd;
  logic          w_wr;
  logic          w_any;
  logic          w_block;
  logic          w_accept;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  master_id_t    w_grant;
  master_id_t    w_head;
  master_id_t    w_locked_id_nxt;
  master_id_t    r_locked_id;
  master_id_t    r_last_grant;
  lock_st_t      r_st;
  lock_st_t      w_st_nxt;
  logic          r_err;

  assign w_req0 = i_m0.read_req | i_m0.write_req;
  assign w_req1 = i_m1.read_req | i_m1.write_req;

  always_comb begin
    w_grant = 1'b0;
    if (r_st == ST_LOCKED) begin
      w_grant = r_locked_id;
    end else if (w_req0 && !w_req1) begin
      w_grant = 1'b0;
    end else if (w_req1 && !w_req0) begin
      w_grant = 1'b1;
    end else if (FIXED_PRIORITY) begin
      w_grant = 1'b0;
    end else begin
      w_grant = rr_pick(r_last_grant);
    end
  end

  assign w_rd = w_grant ? i_m1.read_req : i_m0.read_req;
  assign w_wr = w_grant ? i_m1.write_req : i_m0.write_req;
  assign w_any = w_rd | w_wr;

  // No same-cycle bypass: a pop must register before a new read goes out.
  assign w_block  = w_rd & w_full;
  assign w_accept = reset_n & w_any & o_bus.ready & ~w_block;
  assign w_push   = w_accept & w_rd;

  assign i_m0.ready = w_accept & (w_grant == 1'b0);
  assign i_m1.ready = w_accept & (w_grant == 1'b1);

  assign o_bus.addr =
    w_grant ? i_m1.addr : i_m0.addr;
  assign o_bus.write_data =
    w_grant ? i_m1.write_data : i_m0.write_data;
  assign o_bus.byte_enable =
    w_grant ? i_m1.byte_enable : i_m0.byte_enable;
  assign o_bus.write_req = reset_n & w_wr & ~w_block;
  assign o_bus.read_req  = reset_n & w_rd & ~w_block;

  mem_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_id    (w_grant),
    .i_pop   (o_bus.read_data_valid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign i_m0.read_data = o_bus.read_data;
  assign i_m1.read_data = o_bus.read_data;
  assign i_m0.read_data_valid = reset_n &
    o_bus.read_data_valid & ~w_empty & (w_head == 1'b0);
  assign i_m1.read_data_valid = reset_n &
    o_bus.read_data_valid & ~w_empty & (w_head == 1'b1);

  assign o_err_unexpected_rdata = r_err;

  always_comb begin
    w_st_nxt        = r_st;
    w_locked_id_nxt = r_locked_id;
    unique case (r_st)
      ST_OPEN: begin
        if (w_any && !w_accept) begin
          w_st_nxt        = ST_LOCKED;
          w_locked_id_nxt = w_grant;
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          w_st_nxt = ST_OPEN;
        end
      end
      default: w_st_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st         <= ST_OPEN;
      r_locked_id  <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_locked_id <= w_locked_id_nxt;
      if (w_accept) begin
        r_last_grant <= w_grant;
      end
      if (o_bus.read_data_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, locking, FIFO limits,
// return steering and reset behaviour.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  logic err;
  int   n_chk;
  int   n_err;

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .MAX_OUTSTANDING (4),
    .FIXED_PRIORITY  (1'b0)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .i_m0                   (m0_if),
    .i_m1                   (m1_if),
    .o_bus                  (bus_if),
    .o_err_unexpected_rdata (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic m0_rd(input logic en, input logic [31:0] a);
    m0_if.read_req = en;
    m0_if.addr     = a;
  endtask

  task automatic m1_rd(input logic en, input logic [31:0] a);
    m1_if.read_req = en;
    m1_if.addr     = a;
  endtask

  task automatic m1_wr(input logic en, input logic [31:0] a);
    m1_if.write_req = en;
    m1_if.addr      = a;
  endtask

  task automatic bus(
    input logic        rdy,
    input logic        vld,
    input logic [31:0] d
  );
    bus_if.ready           = rdy;
    bus_if.read_data_valid = vld;
    bus_if.read_data       = d;
  endtask

  task automatic idle();
    m0_if.read_req  = 1'b0;
    m0_if.write_req = 1'b0;
    m1_if.read_req  = 1'b0;
    m1_if.write_req = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    nxt();
    reset_n = 1'b0;
    idle();
    nxt();
    nxt();
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    m0_if.write_data  = 32'h1111_0000;
    m0_if.byte_enable = 4'hF;
    m0_if.write_req   = 1'b0;
    m0_if.addr        = 32'h0;
    m1_if.write_data  = 32'h2222_0000;
    m1_if.byte_enable = 4'h3;
    m1_if.read_req    = 1'b0;
    m1_if.addr        = 32'h0;
    m0_rd(1'b1, 32'h1000_0000);
    bus(1'b1, 1'b0, 32'h0);
    nxt();
    nxt();
    #1;
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_bus_rreq", bus_if.read_req, 0);
    chk("rst_err", err, 0);
    chk("rst_count", dut.w_count, 0);

    // single m0 read with one-cycle return
    nxt();
    reset_n = 1'b1;
    m0_rd(1'b1, 32'h1000_0000);
    #1;
    chk("t1_m0_ready", m0_if.ready, 1);
    chk("t1_bus_addr", bus_if.addr, 32'h1000_0000);
    chk("t1_bus_rreq", bus_if.read_req, 1);
    nxt();
    m0_rd(1'b0, 32'h0);
    bus(1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("t1_m0_ready_off", m0_if.ready, 0);
    chk("t1_m0_valid", m0_if.read_data_valid, 1);
    chk("t1_m1_valid", m1_if.read_data_valid, 0);
    chk("t1_m0_data", m0_if.read_data, 32'hDEAD_BEEF);

    // round-robin with both masters reading every cycle
    do_reset();
    m0_rd(1'b1, 32'h0000_0100);
    m1_rd(1'b1, 32'h0000_0200);
    #1;
    chk("t2_c1_m0_ready", m0_if.ready, 1);
    chk("t2_c1_m1_ready", m1_if.ready, 0);
    chk("t2_c1_addr", bus_if.addr, 32'h100);
    nxt();
    #1;
    chk("t2_c2_m1_ready", m1_if.ready, 1);
    chk("t2_c2_m0_ready", m0_if.ready, 0);
    chk("t2_c2_addr", bus_if.addr, 32'h200);
    nxt();
    #1;
    chk("t2_c3_m0_ready", m0_if.ready, 1);
    nxt();
    #1;
    chk("t2_c4_m1_ready", m1_if.ready, 1);
    nxt();
    m0_rd(1'b0, 32'h0);
    m1_rd(1'b0, 32'h0);
    bus(1'b1, 1'b1, 32'hAAAA_0001);
    #1;
    chk("t2_A_m0", m0_if.read_data_valid, 1);
    chk("t2_A_m1", m1_if.read_data_valid, 0);
    nxt();
    bus(1'b1, 1'b1, 32'hBBBB_0002);
    #1;
    chk("t2_B_m1", m1_if.read_data_valid, 1);
    chk("t2_B_m0", m0_if.read_data_valid, 0);
    chk("t2_B_data", m1_if.read_data, 32'hBBBB_0002);
    nxt();
    bus(1'b1, 1'b1, 32'hCCCC_0003);
    #1;
    chk("t2_C_m0", m0_if.read_data_valid, 1);
    nxt();
    bus(1'b1, 1'b1, 32'hDDDD_0004);
    #1;
    chk("t2_D_m1", m1_if.read_data_valid, 1);
    chk("t2_D_m0", m0_if.read_data_valid, 0);
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk("t2_drained", dut.w_count, 0);

    // stalled m1 write holds the bus against m0
    nxt();
    m1_wr(1'b1, 32'h3000_0010);
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk("t3_c1_addr", bus_if.addr, 32'h3000_0010);
    chk("t3_c1_wreq", bus_if.write_req, 1);
    chk("t3_c1_m1_ready", m1_if.ready, 0);
    nxt();
    m0_rd(1'b1, 32'h0000_0100);
    #1;
    chk("t3_c2_addr", bus_if.addr, 32'h3000_0010);
    chk("t3_c2_m0_ready", m0_if.ready, 0);
    nxt();
    #1;
    chk("t3_c3_addr", bus_if.addr, 32'h3000_0010);
    chk("t3_c3_be", bus_if.byte_enable, 4'h3);
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk("t3_c4_m1_ready", m1_if.ready, 1);
    chk("t3_c4_m0_ready", m0_if.ready, 0);
    chk("t3_c4_addr", bus_if.addr, 32'h3000_0010);
    nxt();
    m1_wr(1'b0, 32'h0);
    #1;
    chk("t3_c5_m0_ready", m0_if.ready, 1);
    chk("t3_c5_addr", bus_if.addr, 32'h100);
    nxt();
    m0_rd(1'b0, 32'h0);
    bus(1'b1, 1'b1, 32'h5555_0005);
    #1;
    chk("t3_ret_m0", m0_if.read_data_valid, 1);

    // fill the FIFO and block the fifth read
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      m0_rd(1'b1, 32'h0000_1000 + 32'(i * 4));
      #1;
      chk("t4_fill_ready", m0_if.ready, 1);
      nxt();
    end
    m0_rd(1'b1, 32'h0000_2000);
    #1;
    chk("t4_full_count", dut.w_count, 4);
    chk("t4_blk_ready", m0_if.ready, 0);
    chk("t4_blk_rreq", bus_if.read_req, 0);
    nxt();
    bus(1'b1, 1'b1, 32'h6666_0006);
    #1;
    chk("t4_pop_ready", m0_if.ready, 0);
    chk("t4_pop_valid", m0_if.read_data_valid, 1);
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk("t4_5th_ready", m0_if.ready, 1);
    chk("t4_5th_rreq", bus_if.read_req, 1);
    nxt();
    m0_rd(1'b0, 32'h0);
    m1_wr(1'b1, 32'h0000_0040);
    #1;
    chk("t4_wr_full_cnt", dut.w_count, 4);
    chk("t4_wr_ready", m1_if.ready, 1);
    chk("t4_wr_wreq", bus_if.write_req, 1);

    // drain to two, then push and pop together
    nxt();
    m1_wr(1'b0, 32'h0);
    bus(1'b1, 1'b1, 32'h0);
    nxt();
    nxt();
    m1_rd(1'b1, 32'h0000_0300);
    bus(1'b1, 1'b1, 32'h7777_0007);
    #1;
    chk("t5_pre_count", dut.w_count, 2);
    chk("t5_m1_ready", m1_if.ready, 1);
    chk("t5_m0_valid", m0_if.read_data_valid, 1);
    nxt();
    m1_rd(1'b0, 32'h0);
    bus(1'b1, 1'b1, 32'h8888_0008);
    #1;
    chk("t5_post_count", dut.w_count, 2);
    chk("t5_r2_m0", m0_if.read_data_valid, 1);
    nxt();
    bus(1'b1, 1'b1, 32'h9999_0009);
    #1;
    chk("t5_r3_m1", m1_if.read_data_valid, 1);
    chk("t5_r3_m0", m0_if.read_data_valid, 0);

    // unexpected return with an empty FIFO
    nxt();
    bus(1'b1, 1'b1, 32'hBAD0_0000);
    #1;
    chk("t6_empty_cnt", dut.w_count, 0);
    chk("t6_m0_valid", m0_if.read_data_valid, 0);
    chk("t6_m1_valid", m1_if.read_data_valid, 0);
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    m0_rd(1'b1, 32'h0000_4000);
    #1;
    chk("t6_err_set", err, 1);
    chk("t6_rd1_ready", m0_if.ready, 1);
    nxt();
    #1;
    chk("t6_rd2_ready", m0_if.ready, 1);
    nxt();
    reset_n = 1'b0;
    bus(1'b1, 1'b1, 32'h0);
    #1;
    chk("t6_rst_count", dut.w_count, 2);
    chk("t6_rst_ready", m0_if.ready, 0);
    chk("t6_rst_rreq", bus_if.read_req, 0);
    chk("t6_rst_valid", m0_if.read_data_valid, 0);
    nxt();
    #1;
    chk("t6_rst_err", err, 0);
    chk("t6_rst_empty", dut.w_count, 0);
    nxt();
    reset_n = 1'b1;
    m0_rd(1'b0, 32'h0);
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk("t6_err_clear", err, 0);
    nxt();
    bus(1'b1, 1'b1, 32'hC0DE_0000);
    #1;
    chk("t6_late_valid", m0_if.read_data_valid, 0);
    nxt();
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk("t6_late_err", err, 1);
    nxt();
    chk("t6_err_sticky", err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
